rx_ber_checker: RTL and testbench

PAM4 symbol/bit error checker sitting directly downstream of the parallel DFE receiver. It buffers the transmitted reference symbols and consumes the DFE's decided levels, which are signalled by a toggling valid. It maps each decided level back to a Gray-coded symbol, compares it against the aligned reference and accumulates saturating symbol, bit and decision counters. Counters are read by the simulation harness to report link BER.

---
 rtl/rx_check_pkg.sv | 39 +++
 rtl/rx_ref_fifo.sv | 49 ++++
 rtl/rx_ber_checker.sv | 150 +++++++++++++++
 tb/tb_rx_ber_checker.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_check_pkg.sv
// Shared definitions for the PAM4 receive-side error checker.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package rx_check_pkg;

    localparam logic [0:0] ST_SKIP = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    typedef struct packed {
        logic       invalid;
        logic [1:0] sym;
    } rx_map_t;

    function automatic int level_outer(input int sep);
        return (3 * sep) / 2;
    endfunction

    function automatic int level_inner(input int sep);
        return sep / 2;
    endfunction

    // Gray-coded decode: adjacent levels differ by exactly one bit.
    function automatic rx_map_t gray_map(input int level, input int sep);
        rx_map_t m;
        m.invalid = 1'b0;
        m.sym     = 2'b00;
        if (level == -level_outer(sep))      m.sym = 2'b00;
        else if (level == -level_inner(sep)) m.sym = 2'b01;
        else if (level == level_inner(sep))  m.sym = 2'b11;
        else if (level == level_outer(sep))  m.sym = 2'b10;
        else                                 m.invalid = 1'b1;
        return m;
    endfunction

    function automatic logic [1:0] popcount2(input logic [1:0] v);
        return {v[1] & v[0], v[1] ^ v[0]};
    endfunction

endpackage

// File: rtl/rx_ref_fifo.sv
// Generic synchronous FIFO with flush; wrap detected via pointer MSB.
// Latency: write visible at head one edge after push; head is combinational.
// Backpressure: push while full and pop while empty are ignored.
module rx_ref_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/rx_ber_checker.sv
// PAM4 decision checker: decodes DFE levels, compares to buffered reference, counts errors.
// Latency: counters reflect a decision 2 edges after its toggle event; one decision per clock.
// Backpressure: tx_ready drops when the reference FIFO is full; excess pushes set overflow.
module rx_ber_checker
    import rx_check_pkg::*;
#(
    parameter int SIGNAL_RESOLUTION = 8,
    parameter int SYMBOL_SEPERATION = 56,
    parameter int FIFO_DEPTH        = 16,
    parameter int SKIP_SYMBOLS      = 4,
    parameter int COUNT_WIDTH       = 32
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic [1:0]                          tx_symbol,
    input  logic                                tx_symbol_valid,
    output logic                                tx_ready,
    input  logic signed [SIGNAL_RESOLUTION-1:0] rx_level,
    input  logic                                rx_toggle,
    input  logic                                clear,
    output logic [COUNT_WIDTH-1:0]              symbol_count,
    output logic [COUNT_WIDTH-1:0]              symbol_errors,
    output logic [COUNT_WIDTH-1:0]              bit_errors,
    output logic                                overflow,
    output logic                                underflow,
    output logic                                invalid_level
);
    localparam int SKW = (SKIP_SYMBOLS > 1) ? $clog2(SKIP_SYMBOLS) : 1;
    localparam logic [SKW-1:0] SKIP_LAST = SKW'((SKIP_SYMBOLS > 0) ? SKIP_SYMBOLS - 1 : 0);

    logic           toggle_q;
    logic           decision;
    logic           push;
    logic           pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [1:0]     fifo_head;
    logic [0:0]     state;
    logic [SKW-1:0] skip_cnt;
    logic           in_run;
    rx_map_t        rx_map;

    logic           s1_vld;
    logic [1:0]     s1_rx_sym;
    logic [1:0]     s1_ref;
    logic           s1_inv;
    logic           s2_err;
    logic [1:0]     s2_bits;

    function automatic logic [COUNT_WIDTH-1:0] sat_add(input logic [COUNT_WIDTH-1:0] a,
                                                       input logic [1:0] inc);
        logic [COUNT_WIDTH:0] sum;
        sum = {1'b0, a} + {{(COUNT_WIDTH-1){1'b0}}, inc};
        return sum[COUNT_WIDTH] ? '1 : sum[COUNT_WIDTH-1:0];
    endfunction

    // A clear swallows the event of its cycle; toggle_q still tracks so no stale event follows.
    assign decision = (rx_toggle ^ toggle_q) & ~clear;
    assign pop      = decision & ~fifo_empty;
    assign push     = tx_symbol_valid & ~clear;
    assign tx_ready = ~fifo_full;
    assign in_run   = (state == ST_RUN) || (SKIP_SYMBOLS == 0);
    assign rx_map   = gray_map(int'(rx_level), SYMBOL_SEPERATION);

    rx_ref_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2)
    ) u_ref_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (clear),
        .push      (push),
        .push_data (tx_symbol),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) toggle_q <= 1'b0;
        else       toggle_q <= rx_toggle;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= ST_SKIP;
            skip_cnt <= '0;
        end else if (clear) begin
            state    <= ST_SKIP;
            skip_cnt <= '0;
        end else if (pop && !in_run) begin
            if (skip_cnt == SKIP_LAST) state <= ST_RUN;
            else                       skip_cnt <= skip_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_vld    <= 1'b0;
            s1_rx_sym <= 2'b00;
            s1_ref    <= 2'b00;
            s1_inv    <= 1'b0;
        end else begin
            s1_vld <= pop & in_run & ~clear;
            if (pop) begin
                s1_rx_sym <= rx_map.sym;
                s1_inv    <= rx_map.invalid;
                s1_ref    <= fifo_head;
            end
        end
    end

    // An undecodable level counts as a full 2-bit miss.
    assign s2_err  = s1_inv | (s1_rx_sym != s1_ref);
    assign s2_bits = s1_inv ? 2'd2 : popcount2(s1_rx_sym ^ s1_ref);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            symbol_count  <= '0;
            symbol_errors <= '0;
            bit_errors    <= '0;
            invalid_level <= 1'b0;
        end else if (clear) begin
            symbol_count  <= '0;
            symbol_errors <= '0;
            bit_errors    <= '0;
            invalid_level <= 1'b0;
        end else if (s1_vld) begin
            symbol_count  <= sat_add(symbol_count, 2'd1);
            symbol_errors <= sat_add(symbol_errors, {1'b0, s2_err});
            bit_errors    <= sat_add(bit_errors, s2_bits);
            if (s1_inv) invalid_level <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (tx_symbol_valid && fifo_full) overflow  <= 1'b1;
            if (decision && fifo_empty)       underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rx_ber_checker.sv
// Bench for rx_ber_checker: queue-based reference model, 32-bit and 4-bit counter instances.
module tb_rx_ber_checker;
    localparam int RES   = 8;
    localparam int SEP   = 56;
    localparam int DEPTH = 16;
    localparam int SKIP  = 4;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]            tx_symbol = 2'b00;
    logic                  tx_symbol_valid = 1'b0;
    logic signed [RES-1:0] rx_level = '0;
    logic                  rx_toggle = 1'b0;
    logic                  clear = 1'b0;

    logic        a_ready, a_ovf, a_unf, a_inv;
    logic [31:0] a_cnt, a_serr, a_berr;
    logic        b_ready, b_ovf, b_unf, b_inv;
    logic [3:0]  b_cnt, b_serr, b_berr;

    rx_ber_checker #(.SIGNAL_RESOLUTION(RES), .SYMBOL_SEPERATION(SEP), .FIFO_DEPTH(DEPTH),
                     .SKIP_SYMBOLS(SKIP), .COUNT_WIDTH(32)) dut_main (
        .clk(clk), .rstn(rstn), .tx_symbol(tx_symbol), .tx_symbol_valid(tx_symbol_valid),
        .tx_ready(a_ready), .rx_level(rx_level), .rx_toggle(rx_toggle), .clear(clear),
        .symbol_count(a_cnt), .symbol_errors(a_serr), .bit_errors(a_berr),
        .overflow(a_ovf), .underflow(a_unf), .invalid_level(a_inv));

    rx_ber_checker #(.SIGNAL_RESOLUTION(RES), .SYMBOL_SEPERATION(SEP), .FIFO_DEPTH(DEPTH),
                     .SKIP_SYMBOLS(SKIP), .COUNT_WIDTH(4)) dut_sat (
        .clk(clk), .rstn(rstn), .tx_symbol(tx_symbol), .tx_symbol_valid(tx_symbol_valid),
        .tx_ready(b_ready), .rx_level(rx_level), .rx_toggle(rx_toggle), .clear(clear),
        .symbol_count(b_cnt), .symbol_errors(b_serr), .bit_errors(b_berr),
        .overflow(b_ovf), .underflow(b_unf), .invalid_level(b_inv));

    // Level for each symbol value, indexed by the 2-bit Gray symbol.
    int lvl_of [4] = '{-(3*SEP)/2, -SEP/2, (3*SEP)/2, SEP/2};

    int tests = 0;
    int fails = 0;

    logic [1:0] ref_q [$];
    longint m_cnt, m_serr, m_berr;
    bit     m_ovf, m_unf, m_inv;
    bit     tog_prev;
    int     skipped;
    bit     pend_vld, pend_err, pend_inv;
    int     pend_bits;

    function automatic int model_sym(input int lvl);
        for (int s = 0; s < 4; s++) if (lvl_of[s] == lvl) return s;
        return -1;
    endfunction

    function automatic longint cap4(input longint v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_serr = 0; m_berr = 0;
        m_ovf = 0; m_unf = 0; m_inv = 0;
        tog_prev = 0; skipped = 0; pend_vld = 0;
        ref_q.delete();
    endtask

    // Effect of one clock edge on the observable state, given the inputs presented to it.
    task automatic model_step();
        bit ev;
        bit popped;
        int occ;
        int rs;
        logic [1:0] d;
        ev = (rx_toggle != tog_prev);
        tog_prev = rx_toggle;
        if (clear) begin
            m_cnt = 0; m_serr = 0; m_berr = 0;
            m_ovf = 0; m_unf = 0; m_inv = 0;
            skipped = 0; pend_vld = 0;
            ref_q.delete();
            return;
        end
        if (pend_vld) begin
            m_cnt++;
            if (pend_err) m_serr++;
            m_berr += pend_bits;
            if (pend_inv) m_inv = 1;
            pend_vld = 0;
        end
        occ = ref_q.size();
        popped = 0;
        if (ev) begin
            if (occ == 0) m_unf = 1;
            else begin
                popped = 1;
                if (skipped < SKIP) skipped++;
                else begin
                    rs = model_sym(int'(rx_level));
                    d  = 2'(rs) ^ ref_q[0];
                    pend_vld  = 1;
                    pend_inv  = (rs < 0);
                    pend_err  = pend_inv || (2'(rs) != ref_q[0]);
                    pend_bits = pend_inv ? 2 : $countones(d);
                end
            end
        end
        if (tx_symbol_valid) begin
            if (occ == DEPTH) m_ovf = 1;
            else              ref_q.push_back(tx_symbol);
        end
        if (popped) void'(ref_q.pop_front());
    endtask

    task automatic check_all();
        check("main.symbol_count",  a_cnt,   m_cnt);
        check("main.symbol_errors", a_serr,  m_serr);
        check("main.bit_errors",    a_berr,  m_berr);
        check("main.overflow",      a_ovf,   m_ovf);
        check("main.underflow",     a_unf,   m_unf);
        check("main.invalid_level", a_inv,   m_inv);
        check("main.tx_ready",      a_ready, ref_q.size() < DEPTH);
        check("sat.symbol_count",   b_cnt,   cap4(m_cnt));
        check("sat.symbol_errors",  b_serr,  cap4(m_serr));
        check("sat.bit_errors",     b_berr,  cap4(m_berr));
        check("sat.invalid_level",  b_inv,   m_inv);
        check("sat.tx_ready",       b_ready, ref_q.size() < DEPTH);
    endtask

    task automatic do_cycle(input bit psh, input logic [1:0] sym, input bit ev,
                            input int lvl, input bit clr);
        tx_symbol_valid = psh;
        tx_symbol       = sym;
        clear           = clr;
        rx_level        = RES'(lvl);
        if (ev) rx_toggle = ~rx_toggle;
        model_step();
        @(posedge clk);
        #1;
        check_all();
        tx_symbol_valid = 1'b0;
        clear           = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(0, 2'b00, 0, 0, 0);
    endtask

    task automatic apply_reset();
        rstn = 1'b0;
        rx_toggle = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] seq [4];
        logic [1:0] pushed [DEPTH];
        int         lvls [3];
        longint     ex_serr [3];
        longint     ex_berr [3];
        seq = '{2'b00, 2'b01, 2'b11, 2'b10};
        lvls = '{84, 28, 0};
        ex_serr = '{1, 2, 3};
        ex_berr = '{1, 3, 5};

        apply_reset();
        check("reset.tx_ready", a_ready, 1);
        check("reset.symbol_count", a_cnt, 0);
        check("reset.symbol_errors", a_serr, 0);
        check("reset.bit_errors", a_berr, 0);
        check("reset.flags", {a_ovf, a_unf, a_inv}, 0);

        // Matching stream, decisions trail pushes by one cycle.
        for (int k = 0; k <= 20; k++)
            do_cycle(k < 20, seq[k % 4], k >= 1, (k >= 1) ? lvl_of[seq[(k-1) % 4]] : 0, 0);
        idle(2);
        check("match.symbol_count", a_cnt, 16);
        check("match.symbol_errors", a_serr, 0);
        check("match.bit_errors", a_berr, 0);
        check("match.sat_count", b_cnt, 15);

        // Reference 00 against +84, +28, then an illegal level 0.
        for (int i = 0; i < 3; i++) begin
            do_cycle(1, 2'b00, 0, 0, 0);
            do_cycle(0, 2'b00, 1, lvls[i], 0);
            idle(2);
            check("err.symbol_errors", a_serr, ex_serr[i]);
            check("err.bit_errors", a_berr, ex_berr[i]);
            check("err.symbol_count", a_cnt, 17 + i);
        end
        check("err.invalid_level", a_inv, 1);

        // Fill past full, drain, then decide on an empty FIFO.
        do_cycle(0, 2'b00, 0, 0, 1);
        for (int i = 0; i < DEPTH; i++) begin
            pushed[i] = 2'($urandom_range(0, 3));
            do_cycle(1, pushed[i], 0, 0, 0);
            if (i == DEPTH - 2) check("full.ready_before", a_ready, 1);
        end
        check("full.tx_ready", a_ready, 0);
        check("full.overflow_before", a_ovf, 0);
        do_cycle(1, 2'b11, 0, 0, 0);
        check("full.overflow", a_ovf, 1);
        for (int i = 0; i < DEPTH; i++) do_cycle(0, 2'b00, 1, lvl_of[pushed[i]], 0);
        idle(2);
        check("drain.symbol_count", a_cnt, DEPTH - SKIP);
        check("drain.symbol_errors", a_serr, 0);
        check("drain.underflow_before", a_unf, 0);
        do_cycle(0, 2'b00, 1, 84, 0);
        idle(2);
        check("empty.underflow", a_unf, 1);
        check("empty.symbol_count", a_cnt, DEPTH - SKIP);

        // Clear coinciding with a decision mid-stream.
        for (int i = 0; i < 8; i++) do_cycle(1, seq[i % 4], i > 0, 84, i == 6);
        do_cycle(0, 2'b00, 0, 0, 1);
        check("clear.symbol_count", a_cnt, 0);
        check("clear.flags", {a_ovf, a_unf, a_inv}, 0);
        check("clear.tx_ready", a_ready, 1);
        for (int i = 0; i < 5; i++) do_cycle(1, 2'b00, 0, 0, 0);
        for (int i = 0; i < 4; i++) do_cycle(0, 2'b00, 1, 84, 0);
        idle(2);
        check("skip.symbol_count", a_cnt, 0);
        do_cycle(0, 2'b00, 1, 84, 0);
        idle(2);
        check("fifth.symbol_count", a_cnt, 1);
        check("fifth.symbol_errors", a_serr, 1);
        check("fifth.bit_errors", a_berr, 1);

        // Reset while a compare is in flight.
        do_cycle(1, 2'b00, 0, 0, 0);
        do_cycle(0, 2'b00, 1, 28, 0);
        apply_reset();
        @(posedge clk);
        #1;
        check("rst.symbol_count", a_cnt, 0);
        check("rst.symbol_errors", a_serr, 0);
        check("rst.bit_errors", a_berr, 0);

        // Randomized traffic with occasional clears.
        for (int i = 0; i < 3000; i++) begin
            int r;
            int lvl;
            r = $urandom_range(0, 7);
            if (r < 3 && ref_q.size() > 0) lvl = lvl_of[ref_q[0]];
            else if (r < 6)                lvl = lvl_of[$urandom_range(0, 3)];
            else                           lvl = int'($urandom_range(0, 255)) - 128;
            do_cycle($urandom_range(0, 99) < 55, 2'($urandom_range(0, 3)),
                     $urandom_range(0, 99) < 50, lvl, $urandom_range(0, 299) == 0);
        end
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
